// File: rtl/sdf_pkg.sv
// Shared types and helpers for the SDF FFT butterfly stages.
package sdf_pkg;

  typedef enum logic [1:0] {IDLE, FILL, BFLY, DRAIN} sdf_state_t;

  // Wide enough for any supported WIDTH plus rounding headroom
  localparam int unsigned SCALE_W = 34;

  function automatic int unsigned sdf_log2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = unsigned'(i + 1);
    end
    return r;
  endfunction

  // Halve with round-half-up
  function automatic logic signed [SCALE_W-1:0] scale(input logic signed [SCALE_W-1:0] x);
    logic signed [SCALE_W-1:0] t;
    t = x + SCALE_W'(1);
    return t >>> 1;
  endfunction

endpackage

// File: rtl/sdf_bf2_core.sv
// Combinational radix-2 butterfly for one complex pair, results halved.
// Build option: SDF_BF2_ROUND_EN selects round-half-up instead of truncation.
module sdf_bf2_core
  import sdf_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_re,
  input  logic [WIDTH-1:0] a_im,
  input  logic [WIDTH-1:0] b_re,
  input  logic [WIDTH-1:0] b_im,
  output logic [WIDTH-1:0] sum_re_c,
  output logic [WIDTH-1:0] sum_im_c,
  output logic [WIDTH-1:0] dif_re_c,
  output logic [WIDTH-1:0] dif_im_c
);

  localparam int unsigned EW = WIDTH + 1;

  // One extra bit holds the full sum/difference; halving brings it back to WIDTH
  function automatic logic [WIDTH-1:0] add_scale(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic sub);
    logic signed [EW-1:0] xe;
    logic signed [EW-1:0] ye;
    logic signed [EW-1:0] r;
    xe = {x[WIDTH-1], x};
    ye = {y[WIDTH-1], y};
    r  = sub ? (xe - ye) : (xe + ye);
`ifdef SDF_BF2_ROUND_EN
    return WIDTH'(scale(SCALE_W'(r)));
`else
    return WIDTH'(r >>> 1);
`endif
  endfunction

  assign sum_re_c = add_scale(a_re, b_re, 1'b0);
  assign sum_im_c = add_scale(a_im, b_im, 1'b0);
  assign dif_re_c = add_scale(a_re, b_re, 1'b1);
  assign dif_im_c = add_scale(a_im, b_im, 1'b1);

endmodule

// File: rtl/sdf_bf2_stage.sv
// Radix-2 SDF butterfly stage: pairs samples DEPTH apart, emits halved sums then stored differences.
// Build option: define SDF_BF2_ROUND_EN for round-half-up scaling (default truncates).
module sdf_bf2_stage
  import sdf_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im
);

  localparam int unsigned CW = sdf_log2(DEPTH) + 1;
  localparam int unsigned SW = 2 * WIDTH;
  localparam int unsigned DW = DEPTH * SW;
  localparam logic [CW-1:0] CNT_HALF_LAST = CW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_LAST      = CW'(2 * DEPTH - 1);

  sdf_state_t        state_q, state_d, mode_c;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              have_diff_q, have_diff_d;
  logic [DW-1:0]     dly_q;
  logic [SW-1:0]     tail_c, shift_in_c;
  logic              shift_en_c;
  logic [WIDTH-1:0]  b_re_c, b_im_c;
  logic [WIDTH-1:0]  sum_re_c, sum_im_c, dif_re_c, dif_im_c;
  logic              do_en_d;
  logic [WIDTH-1:0]  do_re_d, do_im_d;

  // Gaps inside a frame count as zero samples
  assign b_re_c = di_en ? di_re : '0;
  assign b_im_c = di_en ? di_im : '0;
  assign tail_c = dly_q[DW-1 -: SW];

  sdf_bf2_core #(.WIDTH(WIDTH)) u_core (
    .a_re     (tail_c[SW-1:WIDTH]),
    .a_im     (tail_c[WIDTH-1:0]),
    .b_re     (b_re_c),
    .b_im     (b_im_c),
    .sum_re_c (sum_re_c),
    .sum_im_c (sum_im_c),
    .dif_re_c (dif_re_c),
    .dif_im_c (dif_im_c)
  );

  // Next state; mode_c is the operation performed this cycle (frame starts act as FILL)
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    have_diff_d = have_diff_q;
    mode_c      = state_q;
    case (state_q)
      IDLE: begin
        if (di_en) begin
          mode_c  = FILL;
          state_d = FILL;
          cnt_d   = CW'(1);
        end
      end
      FILL: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_HALF_LAST) state_d = BFLY;
      end
      BFLY: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d     = DRAIN;
          have_diff_d = 1'b1;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == '0 && di_en) begin
          mode_c  = FILL;
          state_d = FILL;
        end else if (cnt_q == CNT_HALF_LAST) begin
          state_d     = IDLE;
          cnt_d       = '0;
          have_diff_d = 1'b0;
        end
      end
    endcase
  end

  // Delay-line input and output selection
  always_comb begin
    shift_en_c = 1'b0;
    shift_in_c = '0;
    do_en_d    = 1'b0;
    do_re_d    = '0;
    do_im_d    = '0;
    case (mode_c)
      FILL: begin
        shift_en_c = 1'b1;
        shift_in_c = {b_re_c, b_im_c};
        do_en_d    = have_diff_q;
        if (have_diff_q) {do_re_d, do_im_d} = tail_c;
      end
      BFLY: begin
        shift_en_c = 1'b1;
        shift_in_c = {dif_re_c, dif_im_c};
        do_en_d    = 1'b1;
        do_re_d    = sum_re_c;
        do_im_d    = sum_im_c;
      end
      DRAIN: begin
        shift_en_c = 1'b1;
        do_en_d    = 1'b1;
        {do_re_d, do_im_d} = tail_c;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      have_diff_q <= 1'b0;
      do_en       <= 1'b0;
      do_re       <= '0;
      do_im       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      have_diff_q <= have_diff_d;
      do_en       <= do_en_d;
      do_re       <= do_re_d;
      do_im       <= do_im_d;
    end
  end

  // Feedback delay line holds no state worth resetting: every frame refills it before use
  always_ff @(posedge clock) begin
    if (shift_en_c) dly_q <= {dly_q[DW-SW-1:0], shift_in_c};
  end

endmodule

// File: tb/tb_sdf_bf2_stage.sv
// Scoreboard bench for sdf_bf2_stage with DEPTH=4, WIDTH=16.
module tb_sdf_bf2_stage;

  localparam int unsigned W = 16;
  localparam int unsigned D = 4;
  localparam int unsigned F = 2 * D;

  logic         clock, reset, di_en, do_en;
  logic [W-1:0] di_re, di_im, do_re, do_im;

  sdf_bf2_stage #(.WIDTH(W), .DEPTH(D)) dut (
    .clock (clock),
    .reset (reset),
    .di_en (di_en),
    .di_re (di_re),
    .di_im (di_im),
    .do_en (do_en),
    .do_re (do_re),
    .do_im (do_im)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [2*W-1:0] exp_q[$];
  bit prev_en = 1'b0;
  bit chk_lat = 1'b0;
  int fr_re[F];
  int fr_im[F];
  bit fr_en[F];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "bench timeout");
  end

  task automatic check(input string name, input int got, input int req);
    n_tests++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic push(input int re, input int im);
    exp_q.push_back({W'(re), W'(im)});
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_lin(input int base);
    for (int i = 0; i < F; i++) begin
      fr_re[i] = base + i;
      fr_im[i] = 0;
      fr_en[i] = 1'b1;
    end
  endtask

  task automatic send_frame();
    for (int i = 0; i < F; i++) begin
      di_en = fr_en[i];
      di_re = W'(fr_re[i]);
      di_im = W'(fr_im[i]);
      if (chk_lat) begin
        @(negedge clock);
        check($sformatf("latency_s%0d", i), int'(do_en), (i > int'(D)) ? 1 : 0);
      end
      step();
    end
    di_en = 1'b0;
    di_re = '0;
    di_im = '0;
  endtask

  task automatic wait_out(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      step();
      n++;
    end
    check({name, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (4) step();
  endtask

  // Monitor: every valid output must match the head of the scoreboard, with no gaps mid-burst
  always @(negedge clock) begin
    logic [2*W-1:0] e;
    if (do_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL extra_out: got re=%0d im=%0d, required no output",
                 $signed(do_re), $signed(do_im));
      end else begin
        e = exp_q.pop_front();
        n_tests++;
        if ({do_re, do_im} !== e) begin
          n_fail++;
          $display("FAIL out_data: got re=%0d im=%0d, required re=%0d im=%0d",
                   $signed(do_re), $signed(do_im), $signed(e[2*W-1:W]), $signed(e[W-1:0]));
        end
      end
    end else if (prev_en && exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL out_gap: got do_en=0 with %0d outputs pending, required 1", exp_q.size());
    end
    prev_en = (do_en === 1'b1);
  end

  initial begin
    reset = 1'b1;
    di_en = 1'b0;
    di_re = '0;
    di_im = '0;

    // 1: reset values and idle quiet
    repeat (3) @(posedge clock);
    #1;
    check("rst_en", int'(do_en), 0);
    check("rst_data", int'({do_re, do_im}), 0);
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      check("idle_en", int'(do_en), 0);
      check("idle_data", int'({do_re, do_im}), 0);
    end

    // 2: single frame, with latency of the first sum
    set_lin(1);
    push(3, 0); push(4, 0); push(5, 0); push(6, 0);
    repeat (4) push(-2, 0);
    chk_lat = 1'b1;
    send_frame();
    chk_lat = 1'b0;
    wait_out("t2");

    // 3: back-to-back frames stream without a gap
    push(3, 0); push(4, 0); push(5, 0); push(6, 0);
    repeat (4) push(-2, 0);
    push(11, 0); push(12, 0); push(13, 0); push(14, 0);
    repeat (4) push(-2, 0);
    set_lin(1);
    send_frame();
    set_lin(9);
    send_frame();
    wait_out("t3");

    // 4: odd sums exercise the scaling mode; di_en=0 slots carry junk that must read as zero
    fr_re = '{3, -3, 0, 1234, 0, 0, 0, 777};
    fr_im = '{0, 0, 5, 999, 0, 0, -2, -555};
    fr_en = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
`ifdef SDF_BF2_ROUND_EN
    push(2, 0); push(-1, 0); push(0, 2); push(0, 0);
    push(2, 0); push(-1, 0); push(0, 4); push(0, 0);
`else
    push(1, 0); push(-2, 0); push(0, 1); push(0, 0);
    push(1, 0); push(-2, 0); push(0, 3); push(0, 0);
`endif
    send_frame();
    wait_out("t4");

    // 5: full-scale positive then negative
    for (int i = 0; i < F; i++) begin
      fr_re[i] = 32767;
      fr_im[i] = 32767;
      fr_en[i] = 1'b1;
    end
    repeat (4) push(32767, 32767);
    repeat (4) push(0, 0);
    send_frame();
    wait_out("t5_pos");
    for (int i = 0; i < F; i++) begin
      fr_re[i] = -32768;
      fr_im[i] = -32768;
    end
    repeat (4) push(-32768, -32768);
    repeat (4) push(0, 0);
    send_frame();
    wait_out("t5_neg");

    // 6: reset mid-frame, then a clean frame
    set_lin(1);
    push(3, 0);
    for (int i = 0; i < 5; i++) begin
      di_en = 1'b1;
      di_re = W'(fr_re[i]);
      di_im = '0;
      step();
    end
    di_re = W'(fr_re[5]);
    @(negedge clock);
    #2;
    check("t6_sum_seen", exp_q.size(), 0);
    reset = 1'b1;
    #1;
    check("t6_rst_en", int'(do_en), 0);
    check("t6_rst_data", int'({do_re, do_im}), 0);
    di_en = 1'b0;
    di_re = '0;
    step();
    step();
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      check("t6_quiet", int'(do_en), 0);
    end
    fr_re = '{10, 20, 30, 40, 50, 60, 70, 80};
    fr_im = '{7, 0, -7, 100, 1, 2, 3, 4};
    for (int i = 0; i < F; i++) fr_en[i] = 1'b1;
    push(30, 4); push(40, 1); push(50, -2); push(60, 52);
    push(-20, 3); push(-20, -1); push(-20, -5); push(-20, 48);
    send_frame();
    wait_out("t6_new");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
